// File: rtl/sphn_pong_pkg.sv
// Shared definitions for the pong paddle controller: default screen geometry
// and the paddle direction encoding.
package sphn_pong_pkg;

  localparam int V_ACTIVE_DEFAULT = 480;
  localparam int PADDLE_H_DEFAULT = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } dir_t;

  // A single pressed button picks a direction; both or neither means stand still.
  function automatic dir_t pick_dir(input logic up, input logic down);
    dir_t d;
    d = IDLE;
    if (up && !down) begin
      d = UP;
    end else if (down && !up) begin
      d = DOWN;
    end
    return d;
  endfunction

endpackage

// File: rtl/sphn_debounce.sv
// Button conditioner: two-flop synchronizer followed by a counting debouncer.
// The debounced level only follows the synchronized level after it has
// disagreed for 2^DB_BITS consecutive cycles.
module sphn_debounce #(
  parameter int DB_BITS = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level
);

  logic               sync_a;
  logic               sync_b;
  logic [DB_BITS-1:0] count;

  // Bring the asynchronous button into the pixel clock domain.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
    end else begin
      sync_a <= raw;
      sync_b <= sync_a;
    end
  end

  // Count disagreement cycles; any agreement restarts the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      level <= 1'b0;
    end else if (sync_b != level) begin
      if (count == {DB_BITS{1'b1}}) begin
        level <= sync_b;
        count <= '0;
      end else begin
        count <= DB_BITS'(count + 1'b1);
      end
    end else begin
      count <= '0;
    end
  end

endmodule

// File: rtl/sphn_paddle_ctrl.sv
// Pong paddle controller: debounced up/down buttons drive a direction FSM,
// and the paddle position moves once per frame tick, clamped to the screen.
// Optional feature macro SPHN_PADDLE_ACCEL_EN: the per-frame step ramps from
// 1 up to SPEED while a direction is held.
module sphn_paddle_ctrl
  import sphn_pong_pkg::*;
#(
  parameter int V_ACTIVE = V_ACTIVE_DEFAULT,
  parameter int PADDLE_H = PADDLE_H_DEFAULT,
  parameter int SPEED    = 4,
  parameter int DB_BITS  = 16
) (
  input  logic       pix_clk,
  input  logic       pix_rst,
  input  logic       i_move_up,
  input  logic       i_move_down,
  input  logic       i_frame_tick,
  output logic [9:0] o_paddle_y,
  output logic       o_moving,
  output logic       o_at_limit
);

  localparam int               Y_MAX   = V_ACTIVE - PADDLE_H;
  localparam logic signed [10:0] Y_MAX_S = 11'(Y_MAX);
  localparam logic [9:0]       Y_RESET = 10'(Y_MAX / 2);

  logic               up_db;
  logic               down_db;
  dir_t               dir;
  dir_t               next_dir;
  logic [3:0]         step;
  logic signed [10:0] y_cur;
  logic signed [10:0] y_up;
  logic signed [10:0] y_down;
  logic signed [10:0] y_new;

  sphn_debounce #(.DB_BITS(DB_BITS)) u_db_up (
    .clk   (pix_clk),
    .rst   (pix_rst),
    .raw   (i_move_up),
    .level (up_db)
  );

  sphn_debounce #(.DB_BITS(DB_BITS)) u_db_down (
    .clk   (pix_clk),
    .rst   (pix_rst),
    .raw   (i_move_down),
    .level (down_db)
  );

  assign next_dir = pick_dir(up_db, down_db);

`ifdef SPHN_PADDLE_ACCEL_EN
  logic [3:0] step_q;

  // Ramp the step while one direction is held across ticks; restart on any change.
  always_ff @(posedge pix_clk) begin
    if (pix_rst) begin
      step_q <= 4'd1;
    end else if (next_dir == IDLE || next_dir != dir) begin
      step_q <= 4'd1;
    end else if (i_frame_tick && dir != IDLE && step_q < 4'(SPEED)) begin
      step_q <= step_q + 4'd1;
    end
  end

  assign step = step_q;
`else
  assign step = 4'(SPEED);
`endif

  // Candidate next position, widened and signed so clamping never sees a wrap.
  always_comb begin
    y_cur  = signed'({1'b0, o_paddle_y});
    y_up   = y_cur - signed'({7'b0, step});
    y_down = y_cur + signed'({7'b0, step});
    y_new  = y_cur;
    case (dir)
      UP:      y_new = y_up[10] ? 11'sd0 : y_up;
      DOWN:    y_new = (y_down > Y_MAX_S) ? Y_MAX_S : y_down;
      default: y_new = y_cur;
    endcase
  end

  // Direction FSM, re-evaluated every cycle, with o_moving tracking the state.
  always_ff @(posedge pix_clk) begin
    if (pix_rst) begin
      dir      <= IDLE;
      o_moving <= 1'b0;
    end else begin
      dir      <= next_dir;
      o_moving <= (next_dir != IDLE);
    end
  end

  // Position and limit flag only move on a frame tick; reset discards the tick.
  always_ff @(posedge pix_clk) begin
    if (pix_rst) begin
      o_paddle_y <= Y_RESET;
      o_at_limit <= 1'b0;
    end else if (i_frame_tick) begin
      o_paddle_y <= y_new[9:0];
      o_at_limit <= (y_new == 11'sd0) || (y_new == Y_MAX_S);
    end
  end

endmodule

// File: tb/tb_sphn_paddle_ctrl.sv
// Bench for sphn_paddle_ctrl with a short debounce window (DB_BITS=4).
// Define SPHN_PADDLE_ACCEL_EN for both bench and RTL to cover acceleration.
module tb_sphn_paddle_ctrl;

  localparam int DB   = 4;
  localparam int SPD  = 4;
  localparam int YMAX = 480 - 64;
`ifdef SPHN_PADDLE_ACCEL_EN
  localparam int EXP_AFTER_5 = 194;
`else
  localparam int EXP_AFTER_5 = 188;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       upRaw = 1'b0;
  logic       downRaw = 1'b0;
  logic       tick = 1'b0;
  logic [9:0] paddleY;
  logic       moving;
  logic       atLimit;

  int checks = 0;
  int failures = 0;

  // Reference model state: direction is -1 (up), 0 (still), +1 (down).
  int syncUp1 = 0, syncUp2 = 0, syncDn1 = 0, syncDn2 = 0;
  int debUp = 0, debDn = 0, runUp = 0, runDn = 0;
  int mDir = 0, mY = YMAX / 2, mMoving = 0, mLimit = 0, mStep = 1;

  always #5 clk = ~clk;

  sphn_paddle_ctrl #(
    .V_ACTIVE (480),
    .PADDLE_H (64),
    .SPEED    (SPD),
    .DB_BITS  (DB)
  ) dut (
    .pix_clk      (clk),
    .pix_rst      (rst),
    .i_move_up    (upRaw),
    .i_move_down  (downRaw),
    .i_frame_tick (tick),
    .o_paddle_y   (paddleY),
    .o_moving     (moving),
    .o_at_limit   (atLimit)
  );

  // Behavioural model advanced once per rising edge from the bench inputs.
  always @(posedge clk) begin
    int want;
    int ny;
    if (rst) begin
      syncUp1 = 0; syncUp2 = 0; syncDn1 = 0; syncDn2 = 0;
      debUp = 0; debDn = 0; runUp = 0; runDn = 0;
      mDir = 0; mY = YMAX / 2; mMoving = 0; mLimit = 0;
`ifdef SPHN_PADDLE_ACCEL_EN
      mStep = 1;
`else
      mStep = SPD;
`endif
    end else begin
      want = 0;
      if (debUp != 0 && debDn == 0) want = -1;
      if (debDn != 0 && debUp == 0) want = 1;
      if (tick) begin
        ny = mY + mDir * mStep;
        if (ny < 0) ny = 0;
        if (ny > YMAX) ny = YMAX;
        mY = ny;
        mLimit = (ny == 0 || ny == YMAX) ? 1 : 0;
      end
`ifdef SPHN_PADDLE_ACCEL_EN
      if (want == 0 || want != mDir) mStep = 1;
      else if (tick && mStep < SPD) mStep = mStep + 1;
`endif
      mDir = want;
      mMoving = (want != 0) ? 1 : 0;
      if (syncUp2 != debUp) begin
        runUp++;
        if (runUp == (1 << DB)) begin debUp = syncUp2; runUp = 0; end
      end else runUp = 0;
      if (syncDn2 != debDn) begin
        runDn++;
        if (runDn == (1 << DB)) begin debDn = syncDn2; runDn = 0; end
      end else runDn = 0;
      syncUp2 = syncUp1; syncUp1 = int'(upRaw);
      syncDn2 = syncDn1; syncDn1 = int'(downRaw);
    end
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs, then compare all outputs against the model.
  task automatic applyStimulus(input logic u, input logic d, input logic t, input logic r);
    upRaw = u;
    downRaw = d;
    tick = t;
    rst = r;
    @(negedge clk);
    checkOutput("model_paddle_y", int'(paddleY), mY);
    checkOutput("model_moving", int'(moving), mMoving);
    checkOutput("model_at_limit", int'(atLimit), mLimit);
  endtask

  initial begin
    @(negedge clk);
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("reset_y", int'(paddleY), 208);
    checkOutput("reset_moving", int'(moving), 0);
    checkOutput("reset_at_limit", int'(atLimit), 0);
    repeat (5) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

    // Short press must be swallowed by the debouncer.
    repeat (10) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (30) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("glitch_moving", int'(moving), 0);
    end

    // Hold up, then five spaced ticks.
    repeat (24) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("up_moving", int'(moving), 1);
    repeat (5) begin
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
      repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    end
    checkOutput("up_5_ticks_y", int'(paddleY), EXP_AFTER_5);

    // Drive into the top limit.
    repeat (60) begin
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    end
    checkOutput("top_clamp_y", int'(paddleY), 0);
    checkOutput("top_at_limit", int'(atLimit), 1);

    // Drive into the bottom limit.
    repeat (24) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (120) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    end
    checkOutput("bottom_clamp_y", int'(paddleY), YMAX);
    checkOutput("bottom_at_limit", int'(atLimit), 1);

    // Both buttons: paddle stays put across ticks.
    repeat (24) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("both_moving", int'(moving), 0);
    repeat (3) begin
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    end
    checkOutput("both_hold_y", int'(paddleY), YMAX);

    // Reset coinciding with a tick while moving down.
    repeat (24) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("pre_reset_moving", int'(moving), 1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    checkOutput("reset_tick_y", int'(paddleY), 208);
    checkOutput("reset_tick_limit", int'(atLimit), 0);
    repeat (4) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

    // Random button segments with sporadic ticks and rare resets.
    for (int seg = 0; seg < 250; seg++) begin
      logic u;
      logic d;
      int len;
      u = 1'($urandom_range(0, 1));
      d = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) len = int'($urandom_range(1, 12));
      else len = int'($urandom_range(18, 60));
      for (int c = 0; c < len; c++) begin
        applyStimulus(u, d, $urandom_range(0, 4) == 0, $urandom_range(0, 499) == 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sphn_paddle_ctrl.md
SPHN_PADDLE_CTRL -- requirements
Module: sphn_paddle_ctrl

Interface
REQ-001 Parameter V_ACTIVE, default 480, visible lines per frame.
REQ-002 Parameter PADDLE_H, default 64, paddle height in lines.
REQ-003 Parameter SPEED, default 4, maximum lines moved per frame; range 1..15.
REQ-004 Parameter DB_BITS, default 16, debounce counter width in pix_clk cycles.
REQ-005 pix_clk  in  1  pixel clock; the only clock; all state changes on its rising edge.
REQ-006 pix_rst  in  1  reset; synchronous, active-high.
REQ-007 i_move_up  in  1  raw, asynchronous "up" button, active-high.
REQ-008 i_move_down  in  1  raw, asynchronous "down" button, active-high.
REQ-009 i_frame_tick  in  1  one-cycle pulse from VGA timing at the start of vertical blank.
REQ-010 o_paddle_y  out  10  top line of the paddle, consumed by the renderer.
REQ-011 o_moving  out  1  high while a single valid direction is held.
REQ-012 o_at_limit  out  1  high when o_paddle_y equals 0 or Y_MAX.

Function
REQ-013 Y_MAX SHALL equal V_ACTIVE-PADDLE_H (416 at defaults).
REQ-014 Each button SHALL pass through a 2-flop synchronizer before any use.
REQ-015 Debounce: while the synced level differs from the debounced level, a counter increments; at count 2^DB_BITS-1 the debounced level takes the synced level and the counter clears.
REQ-016 The debounce counter SHALL clear on any cycle where the synced level equals the debounced level.
REQ-017 Direction FSM states are IDLE, UP, DOWN, re-evaluated every cycle from the debounced levels.
REQ-018 Transitions: up-only -> UP; down-only -> DOWN; both or neither -> IDLE; direct UP<->DOWN is allowed.
REQ-019 o_moving SHALL be high exactly in UP or DOWN.
REQ-020 On an i_frame_tick cycle in UP: y <= max(y-step, 0); in DOWN: y <= min(y+step, Y_MAX); in IDLE: y unchanged.
REQ-021 Position arithmetic SHALL use 11-bit signed intermediates so that no underflow or overflow wraps.
REQ-022 o_paddle_y SHALL change only on the cycle following an i_frame_tick, with 1-cycle latency, and holds otherwise.
REQ-023 Without acceleration, step SHALL equal SPEED.
REQ-024 o_at_limit SHALL be registered and SHALL update in the same cycle as o_paddle_y.

Reset
REQ-025 While pix_rst is high, on each edge: o_paddle_y <= Y_MAX/2 (208), FSM <= IDLE, the debounced levels, synchronizers and counters <= 0, o_moving <= 0, o_at_limit <= 0, and step <= its reset value.
REQ-026 Reset asserted mid-frame or during a tick SHALL override the tick, and the position update SHALL be discarded.

Configuration
REQ-027 Macro SPHN_PADDLE_ACCEL_EN: when defined, step starts at 1, increments by 1 on each i_frame_tick spent in the same UP or DOWN state, and saturates at SPEED.
REQ-028 With SPHN_PADDLE_ACCEL_EN, step SHALL reset to 1 on entering IDLE, on a direction change, or on reset, and the tick that applies a step uses its pre-increment value.
REQ-029 Without SPHN_PADDLE_ACCEL_EN, no step register SHALL exist and the behaviour is REQ-023.

Structure
REQ-030 Package sphn_pong_pkg SHALL hold the V_ACTIVE and PADDLE_H defaults and the dir_t enum (IDLE, UP, DOWN).
REQ-031 The synchronizer and debounce logic SHALL live in a sub-module sphn_debounce, instantiated once per button.

Verification
REQ-032 Reset check: pulse pix_rst -> o_paddle_y=208, o_moving=0, o_at_limit=0.
REQ-033 Glitch rejection (DB_BITS=4 for the bench): pulse up for 10 cycles -> no debounced change, o_moving stays 0.
REQ-034 Up movement: hold up, no accel, 5 ticks -> o_paddle_y 208->188; with accel the sequence is 207,205,202,198,194.
REQ-035 Clamp at limits: y=2, up held, tick -> 0 and o_at_limit=1; y=414, down held, tick -> 416 and o_at_limit=1.
REQ-036 Both buttons held -> IDLE, o_moving=0, y unchanged across 3 ticks.
REQ-037 Reset with tick: pix_rst and i_frame_tick high together, with down held -> y=208 the next cycle.
